// File: rtl/sys_clock_pkg.sv
// Shared state encoding, default parameters and counter sizing for the
// system clock controller.
package sys_clock_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RELEASE   = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam int DEF_CH_NUM      = 4;
  localparam int DEF_DIV_W       = 8;
  localparam int DEF_LOCK_CYCLES = 1024;
  localparam int DEF_STAGGER     = 16;

  // Bits needed to hold every value from 0 to max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sys_clock_ctrl_clk_en_div.sv
// Programmable clock-enable divider for one channel: emits a one-cycle pulse
// every D cycles while active, with D re-sampled only at period boundaries.
module clk_en_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             active,
  input  logic [DIV_W-1:0] div,
  output logic             clk_en
);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_lat;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] period;
  logic             running;

  assign div_eff = (div == '0) ? DIV_W'(1) : div;

  // On the first active cycle the latched ratio is stale, so take the live one.
  assign period = running ? div_lat : div_eff;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      div_lat <= DIV_W'(1);
      running <= 1'b0;
      clk_en  <= 1'b0;
    end else if (!active) begin
      div_cnt <= '0;
      running <= 1'b0;
      clk_en  <= 1'b0;
    end else begin
      running <= 1'b1;
      if (div_cnt == period - DIV_W'(1)) begin
        clk_en  <= 1'b1;
        div_cnt <= '0;
        div_lat <= div_eff;
      end else begin
        clk_en  <= 1'b0;
        div_cnt <= div_cnt + DIV_W'(1);
        div_lat <= period;
      end
    end
  end

endmodule

// File: rtl/sys_clock_ctrl.sv
// System clock controller: qualifies the clock wizard lock, staggers channel
// reset release and drives one clock-enable divider per derived channel.
module sys_clock_ctrl
  import sys_clock_pkg::*;
#(
  parameter int CH_NUM      = DEF_CH_NUM,
  parameter int DIV_W       = DEF_DIV_W,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int STAGGER     = DEF_STAGGER
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    locked_i,
  input  logic [CH_NUM-1:0]       ch_en,
  input  logic [CH_NUM*DIV_W-1:0] div_cfg,
  output logic [CH_NUM-1:0]       clk_en,
  output logic [CH_NUM-1:0]       ch_rst_n,
  output logic                    ready,
  output logic                    lock_lost
);

  localparam int LCW = cnt_width(LOCK_CYCLES);
  localparam int SCW = cnt_width(STAGGER * CH_NUM);

  logic              sync_q;
  logic              locked_s;
  state_t            state;
  state_t            state_nxt;
  logic [LCW-1:0]    lock_cnt;
  logic [SCW-1:0]    stg_cnt;
  logic              lock_last;
  logic              lock_drop;
  logic [CH_NUM-1:0] ch_rst_n_nxt;
  logic              ready_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q   <= locked_i;
      locked_s <= sync_q;
    end
  end

  assign lock_last = (lock_cnt == LCW'(LOCK_CYCLES - 1));
  assign lock_drop = ((state == RELEASE) || (state == RUN)) && !locked_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= WAIT_LOCK;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_LOCK: if (locked_s && lock_last) state_nxt = RELEASE;
      RELEASE: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
        end else if (ch_rst_n[CH_NUM-1]) begin
          state_nxt = RUN;
        end
      end
      RUN:       if (!locked_s) state_nxt = WAIT_LOCK;
      default:   state_nxt = WAIT_LOCK;
    endcase
  end

  // Channel i leaves reset once the stagger counter has covered (i+1) slots.
  always_comb begin
    ch_rst_n_nxt = '0;
    if (state == RELEASE && !lock_drop) begin
      ch_rst_n_nxt = ch_rst_n;
      for (int i = 0; i < CH_NUM; i++) begin
        if (stg_cnt == SCW'(STAGGER * (i + 1) - 1)) begin
          ch_rst_n_nxt[i] = 1'b1;
        end
      end
    end else if (state == RUN && !lock_drop) begin
      ch_rst_n_nxt = ch_rst_n;
    end
    ready_nxt = (state_nxt == RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_cnt  <= '0;
      stg_cnt   <= '0;
      ch_rst_n  <= '0;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      ch_rst_n  <= ch_rst_n_nxt;
      ready     <= ready_nxt;
      lock_lost <= lock_drop;
      case (state)
        WAIT_LOCK: begin
          if (!locked_s || lock_last) begin
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + LCW'(1);
          end
          stg_cnt <= '0;
        end
        RELEASE: begin
          lock_cnt <= '0;
          if (state_nxt == RELEASE) begin
            stg_cnt <= stg_cnt + SCW'(1);
          end
        end
        default: lock_cnt <= '0;
      endcase
    end
  end

  // A lock drop must silence the dividers on the very edge it is seen.
  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    clk_en_div #(
      .DIV_W(DIV_W)
    ) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .active(ch_rst_n[g] & ch_en[g] & ~lock_drop),
      .div   (div_cfg[g*DIV_W +: DIV_W]),
      .clk_en(clk_en[g])
    );
  end

endmodule

// File: tb/tb_sys_clock_ctrl.sv
// Scoreboard bench for sys_clock_ctrl: a time-based reference model queues the
// expected outputs every edge and a monitor compares them half a cycle later.
module tb_sys_clock_ctrl;

  localparam int CH = 4;
  localparam int DW = 8;
  localparam int LC = 8;
  localparam int ST = 16;

  typedef struct packed {
    logic [CH-1:0] clk_en;
    logic [CH-1:0] ch_rst_n;
    logic          ready;
    logic          lock_lost;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             locked_i = 1'b0;
  logic [CH-1:0]    ch_en = '0;
  logic [CH*DW-1:0] div_cfg = '0;
  logic [CH-1:0]    clk_en;
  logic [CH-1:0]    ch_rst_n;
  logic             ready;
  logic             lock_lost;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t exp_q[$];

  sys_clock_ctrl #(
    .CH_NUM(CH), .DIV_W(DW), .LOCK_CYCLES(LC), .STAGGER(ST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .locked_i(locked_i), .ch_en(ch_en),
    .div_cfg(div_cfg), .clk_en(clk_en), .ch_rst_n(ch_rst_n),
    .ready(ready), .lock_lost(lock_lost)
  );

  always #5 clk = ~clk;

  // Reference model: release progress is an age in cycles since the lock
  // window closed, and each divider is a count of active cycles compared
  // against the cycle number of its next scheduled pulse.
  logic          m_s1, m_s2, m_ls, m_lost;
  int            m_good, m_age;
  int            m_since[CH];
  int            m_next[CH];
  logic [CH-1:0] m_rstn, m_en;
  exp_t          m_e;

  function automatic int eff_div(input logic [DW-1:0] v);
    return (v == '0) ? 1 : int'(v);
  endfunction

  always @(posedge clk) begin
    m_e = '0;
    if (!rst_n) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_good = 0; m_age = -1; m_rstn = '0;
      for (int i = 0; i < CH; i++) begin m_since[i] = 0; m_next[i] = 0; end
    end else begin
      m_ls = m_s2; m_s2 = m_s1; m_s1 = locked_i;
      m_lost = (m_age >= 0) && !m_ls;
      m_en = '0;
      for (int i = 0; i < CH; i++) begin
        if (m_rstn[i] && ch_en[i] && !m_lost) begin
          if (m_since[i] == 0) m_next[i] = eff_div(div_cfg[i*DW +: DW]);
          m_since[i]++;
          if (m_since[i] == m_next[i]) begin
            m_en[i] = 1'b1;
            m_next[i] += eff_div(div_cfg[i*DW +: DW]);
          end
        end else begin
          m_since[i] = 0;
        end
      end
      if (m_age >= 0) begin
        if (!m_ls) begin m_age = -1; m_good = 0; end
        else if (m_age < 100000) m_age++;
      end else if (m_ls) begin
        m_good++;
        if (m_good == LC) begin m_age = 0; m_good = 0; end
      end else begin
        m_good = 0;
      end
      for (int i = 0; i < CH; i++) m_rstn[i] = (m_age >= ST * (i + 1));
      m_e.clk_en    = m_en;
      m_e.ch_rst_n  = m_rstn;
      m_e.ready     = (m_age >= ST * CH + 1);
      m_e.lock_lost = m_lost;
    end
    exp_q.push_back(m_e);
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        checkOutput("clk_en",    32'(clk_en),    32'(e.clk_en));
        checkOutput("ch_rst_n",  32'(ch_rst_n),  32'(e.ch_rst_n));
        checkOutput("ready",     32'(ready),     32'(e.ready));
        checkOutput("lock_lost", 32'(lock_lost), 32'(e.lock_lost));
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic l, input logic [CH-1:0] en,
                               input logic [CH*DW-1:0] cfg, input int cycles);
    @(negedge clk);
    rst_n = r; locked_i = l; ch_en = en; div_cfg = cfg;
    repeat (cycles - 1) @(negedge clk);
  endtask

  function automatic logic [CH*DW-1:0] cfg4(input int d3, input int d2, input int d1,
                                            input int d0);
    return {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
  endfunction

  initial begin : stimulus
    int first0, first3, first_rdy;
    logic          r_rst, r_lck;
    logic [CH-1:0] r_en;
    logic [CH*DW-1:0] r_cfg;

    applyStimulus(1'b0, 1'b0, '0, '0, 3);
    applyStimulus(1'b1, 1'b0, '0, '0, 4);

    // Directed release timing from the lock rising edge.
    applyStimulus(1'b1, 1'b1, '0, '0, 1);
    first0 = 0; first3 = 0; first_rdy = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (ch_rst_n[0] && first0 == 0) first0 = n;
      if (ch_rst_n[3] && first3 == 0) first3 = n;
      if (ready && first_rdy == 0) first_rdy = n;
    end
    checkOutput("ch0_release_cycle", 32'(first0), 32'(2 + LC + ST));
    checkOutput("ch3_release_cycle", 32'(first3), 32'(2 + LC + 4 * ST));
    checkOutput("ready_cycle",       32'(first_rdy), 32'(3 + LC + 4 * ST));

    // Divider ratios in RUN, including 0/1 and a mid-period change.
    applyStimulus(1'b1, 1'b1, 4'b0001, cfg4(0, 0, 0, 4), 20);
    applyStimulus(1'b1, 1'b1, 4'b0001, cfg4(0, 0, 0, 0), 8);
    applyStimulus(1'b1, 1'b1, 4'b0001, cfg4(0, 0, 0, 1), 8);
    applyStimulus(1'b1, 1'b1, 4'b1111, cfg4(2, 5, 3, 4), 6);
    applyStimulus(1'b1, 1'b1, 4'b1111, cfg4(2, 5, 3, 7), 30);
    applyStimulus(1'b1, 1'b1, 4'b1101, cfg4(2, 5, 3, 7), 5);
    applyStimulus(1'b1, 1'b1, 4'b1111, cfg4(2, 5, 3, 7), 12);

    // Lock loss in RUN, then relock with a one-cycle glitch mid-window.
    applyStimulus(1'b1, 1'b0, 4'b1111, cfg4(2, 5, 3, 1), 6);
    applyStimulus(1'b1, 1'b1, 4'b1111, cfg4(2, 5, 3, 1), 7);
    applyStimulus(1'b1, 1'b0, 4'b1111, cfg4(2, 5, 3, 1), 1);
    applyStimulus(1'b1, 1'b1, 4'b1111, cfg4(2, 5, 3, 1), 100);

    // Lock loss in RELEASE, then synchronous reset in RELEASE.
    applyStimulus(1'b1, 1'b0, 4'b1111, cfg4(2, 5, 3, 1), 4);
    applyStimulus(1'b1, 1'b1, 4'b1111, cfg4(2, 5, 3, 1), 30);
    applyStimulus(1'b1, 1'b0, 4'b1111, cfg4(2, 5, 3, 1), 4);
    applyStimulus(1'b1, 1'b1, 4'b1111, cfg4(2, 5, 3, 1), 40);
    applyStimulus(1'b0, 1'b1, 4'b1111, cfg4(2, 5, 3, 1), 2);
    applyStimulus(1'b1, 1'b1, 4'b1111, cfg4(2, 5, 3, 1), 90);

    // Randomised operation.
    r_rst = 1'b1; r_lck = 1'b1; r_en = 4'b1111; r_cfg = cfg4(2, 5, 3, 4);
    for (int k = 0; k < 2500; k++) begin
      r_rst = ($urandom_range(0, 1499) != 0);
      if (r_lck) r_lck = ($urandom_range(0, 399) != 0);
      else       r_lck = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 39) == 0) r_en[i] = ~r_en[i];
        if ($urandom_range(0, 29) == 0) r_cfg[i*DW +: DW] = DW'($urandom_range(0, 9));
      end
      applyStimulus(r_rst, r_lck, r_en, r_cfg, 1);
    end

    applyStimulus(1'b1, r_lck, r_en, r_cfg, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
